vga_scan_timing: RTL
====================

Name: vga_scan_timing

Overview:
- Raster timing generator that drives the scan interface consumed by the sprite/bullet layers: `display_col`, `display_row`, `calc` and the VGA sync pins.
- `calc` marks the vertical-blanking window in which object layers update their state.
- Outside that window the layers render against the live `display_col`/`display_row`.
- Sits at top level between the pixel clock domain and every layer module plus the VGA DAC.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clock  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel advance enable; counters step only when high
- display_col  out  12  current column, 0..H_TOTAL-1
- display_row  out  11  current row, 0..V_TOTAL-1
- active  out  1  high when col < H_ACTIVE and row < V_ACTIVE
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- calc  out  1  high while row >= V_ACTIVE (vertical blanking)
- line_start  out  1  one-cycle pulse when col wraps to 0
- frame_start  out  1  one-cycle pulse when col and row both wrap to 0

Behaviour:
- Reset and reset values:
  - Single clock; reset is asynchronous and active-high.
  - On reset all outputs are registered to: col=0, row=0, active=0, calc=0, line_start=0, frame_start=0, hsync=vsync=!SYNC_POL (inactive).
  - Reset asserted mid-frame returns immediately to these values.
  - After reset release, the first pix_en cycle moves to col=1; no frame_start pulse is issued for the reset frame.
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 1344.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP = 806.
  - Elaboration must fail if H_TOTAL > 4096 or V_TOTAL > 2048.
- Counters:
  - On a clock edge with pix_en=1: col increments.
  - At col = H_TOTAL-1, col wraps to 0 and row increments.
  - At row = V_TOTAL-1 with col = H_TOTAL-1, row wraps to 0.
  - With pix_en=0, every output holds its value, except that line_start and frame_start drop to 0.
- Output registration:
  - All outputs are registered and describe the same (col,row) pair in the same cycle, with zero skew between them.
  - Each output is decoded from the next-state counter values so that it stays aligned with display_col/display_row.
- Output decode from (col,row):
  - active = col < H_ACTIVE && row < V_ACTIVE.
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC; otherwise !SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC; otherwise !SYNC_POL. It is a whole-line decode.
  - calc = row >= V_ACTIVE. It rises at (col 0, row V_ACTIVE) and falls at (col 0, row 0). Its high period is a contiguous (V_TOTAL-V_ACTIVE)*H_TOTAL enabled cycles.
  - line_start = 1 in the cycle where col == 0 was just entered via wrap.
  - frame_start = line_start && row == 0.
- Consumer contract:
  - calc never glitches within a frame.
  - calc is low for at least one enabled cycle between blanking windows, so consumers can detect rising edges.

Decomposition:
- Shared package `vga_timing_pkg`:
  - default timing constants (1024x768@60 set above);
  - localparams for H_TOTAL and V_TOTAL;
  - col/row width constants (12, 11) used by all layer modules.
- No sub-module is required. A generic `wrap_counter` (max value, enable, wrap pulse) may be instantiated twice, once for col and once for row.

Test Plan:
- Assert reset mid-line at col=500, row=300 -> next sample col=0, row=0, hsync=vsync=1, calc=0, active=0; no frame_start on release.
- pix_en=1 continuously for one line -> col runs 0..1343 then 0; hsync low exactly for col 1048..1183 (136 cycles); active high for col 0..1023; line_start pulses once.
- pix_en=1 for a full frame -> calc rises at (0,768) and stays high 38*1344 = 51072 cycles; vsync low for rows 771..776; frame_start pulses exactly once at (0,0); period = 1,083,264 cycles.
- pix_en toggling 1/0 each cycle -> all counts advance on enabled cycles only; line_start/frame_start last one cycle each; period doubles to 2,166,528 clocks.
- Small parameter set (H 8/1/2/1, V 4/1/1/1) -> exhaustive compare against a reference model over 3 frames, including the wrap at (11,6)->(0,0).
- Hold pix_en=0 across col=1343, row=805 for 20 cycles, then release -> wrap occurs on the first enabled cycle; frame_start issued once.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 1024x768@60 raster constants shared by the timing generator and layer modules.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP = 24;
  localparam int DEF_H_SYNC = 136;
  localparam int DEF_H_BP = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP = 3;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP = 29;
  localparam bit DEF_SYNC_POL = 1'b0;
  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int COL_W = 12;
  localparam int ROW_W = 11;
endpackage

// File: rtl/vga_scan_timing_counter.sv
// vga_scan_timing_counter: enabled modulo counter exposing its next value and a wrap strobe.
module vga_scan_timing_counter #(
  parameter int W = 12,
  parameter int MAX = 1343
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] next,
  output logic         wrap
);
  assign wrap = en && count == W'(MAX);
  assign next = wrap ? '0 : count + W'(en);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= next;
endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster col/row generator with sync, active, blanking (calc) and line/frame strobes.
// Decoded outputs are computed from the counters' next values so they register alongside col/row.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  output logic [COL_W-1:0] display_col,
  output logic [ROW_W-1:0] display_row,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             calc,
  output logic             line_start,
  output logic             frame_start
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COL_W-1:0] HA = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] HS0 = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] HS1 = COL_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_W-1:0] VA = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] VS0 = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] VS1 = ROW_W'(V_ACTIVE + V_FP + V_SYNC);
  generate
    if (HT > 4096 || VT > 2048) begin : g_too_big
      $error("vga_scan_timing: H_TOTAL or V_TOTAL exceeds counter width");
    end
  endgenerate
  logic [COL_W-1:0] col_n;
  logic [ROW_W-1:0] row_n;
  logic h_wrap, v_wrap;
  vga_scan_timing_counter #(.W(COL_W), .MAX(HT - 1)) u_col (
    .clock(clock), .reset(reset), .en(pix_en),
    .count(display_col), .next(col_n), .wrap(h_wrap)
  );
  vga_scan_timing_counter #(.W(ROW_W), .MAX(VT - 1)) u_row (
    .clock(clock), .reset(reset), .en(h_wrap),
    .count(display_row), .next(row_n), .wrap(v_wrap)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      active <= 1'b0;
      hsync <= !SYNC_POL;
      vsync <= !SYNC_POL;
      calc <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start <= h_wrap;
      frame_start <= v_wrap;
      if (pix_en) begin
        active <= col_n < HA && row_n < VA;
        hsync <= (col_n >= HS0 && col_n < HS1) ? SYNC_POL : !SYNC_POL;
        vsync <= (row_n >= VS0 && row_n < VS1) ? SYNC_POL : !SYNC_POL;
        calc <= row_n >= VA;
      end
    end
endmodule
